decoder_register_bank: RTL and testbench
========================================

# decoder_register_bank

Parameterised bank of 2^A enabled storage registers with a one-hot write-address decoder and two asynchronous read ports. It is the general-purpose register store of the single-issue CPU datapath: one write per clock, two operand reads per cycle. Entry 0 is the architectural zero register.

## Interface

Parameters:
- N, default 32: data width of every entry.
- A, default 5: address width. Depth is 2^A entries (32 by default).

Ports:
- clk, input, 1: the only clock. All state updates occur on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- wr_ena, input, 1: write enable.
- wr_addr, input, A: write address.
- wr_data, input, N: write data.
- rd_addr1, input, A: read address for port 1.
- rd_addr2, input, A: read address for port 2.
- rd_data1, output, N: read data for port 1. Combinational.
- rd_data2, output, N: read data for port 2. Combinational.
- wr_onehot, output, 2^A: decoded write strobes. Bit k = wr_ena AND (wr_addr == k). Exposed for verification.

## Operation

- Decoder: an A-to-2^A one-hot decoder gated by wr_ena. When wr_ena=0, all bits are 0. When wr_ena=1, exactly one bit is 1, at index wr_addr.
- Register entry k (k ≥ 1): an N-bit flip-flop with enable.
  - If rst=1 at a clock edge, q becomes 0.
  - Else, if wr_onehot[k]=1, q becomes wr_data.
  - Otherwise q holds its value.
- Entry 0 (with REG0_ZERO_EN defined):
  - No storage. It always reads as all-zeros.
  - A write to address 0 is discarded, with no side effects.
- Read ports:
  - rd_dataX is a pure mux of the current entry contents selected by rd_addrX.
  - The two ports are independent and may select the same entry.
  - Every address maps to an entry, so there is no undefined read.
- Data is uninterpreted bits. There is no sign extension and no truncation, since all paths are exactly N bits.

## Timing

- Write latency: 1 cycle. Data presented with wr_ena=1 before edge T is visible on a read port immediately after edge T.
- Read latency: 0 cycles. rd_data follows rd_addr and the register contents combinationally.
- Read during write to the same address in the same cycle: the read returns the old value until the edge. There is no write-through bypass.
- Reset has priority over a write. With rst=1 and wr_ena=1 on the same edge, the entry ends at 0.
- Reset values:
  - All stored entries are 0 after the first edge with rst=1.
  - rd_data1 and rd_data2 are therefore 0 after reset for any address.
  - wr_onehot is combinational and is not affected by rst.
- Reset asserted mid-operation clears all entries at the next edge, regardless of any pending write.
- Before the first reset, entry contents are undefined (X in simulation). The bench must reset first.

## Configuration

- REG0_ZERO_EN:
  - Defined (the project default): entry 0 is hardwired to zero, as described above. wr_onehot[0] is still produced but has no effect.
  - Undefined: entry 0 is an ordinary register, identical to all others. It resets to 0, is writable, and reads back its stored value.

## Test plan

1. Reset: hold rst=1 for 1 cycle with wr_ena=1, wr_addr=5, wr_data=32'hFFFF_FFFF. Then with rst=0, reading every address 0–31 on both ports returns 0.
2. Write/readback: write 32'hDEAD_BEEF to address 7. On the next cycle, rd_addr1=7 gives 32'hDEAD_BEEF and rd_addr2=8 gives 0. With wr_ena=0 and wr_data changed, address 7 still reads 32'hDEAD_BEEF.
3. Zero register (REG0_ZERO_EN defined): write 32'h1234_5678 to address 0, then read address 0 → 0. The same test without the macro → 32'h1234_5678.
4. Decoder: sweep wr_addr 0–31 with wr_ena=1 → wr_onehot == 1<<wr_addr. With wr_ena=0 → wr_onehot == 0 for all addresses.
5. Same-cycle read/write: address 3 holds 32'hA, then write 32'hB to it. Before the edge, rd_addr1=3 → 32'hA. After the edge → 32'hB. Both ports read address 3 simultaneously → equal values.
6. Fill and verify: write value k*32'h0101_0101 to each address k = 1..31. Read all of them back through both ports with distinct addresses → all match. Then a mid-sequence rst clears everything to 0.

Source files
------------

// File: rtl/decoder_register_bank.sv
// decoder_register_bank: 2^A x N register store, one-hot write decode, two async read ports; REG0_ZERO_EN hardwires entry 0 to zero
module decoder_register_bank #(
  parameter int N = 32,
  parameter int A = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_ena,
  input  logic [A-1:0]    wr_addr,
  input  logic [N-1:0]    wr_data,
  input  logic [A-1:0]    rd_addr1,
  input  logic [A-1:0]    rd_addr2,
  output logic [N-1:0]    rd_data1,
  output logic [N-1:0]    rd_data2,
  output logic [2**A-1:0] wr_onehot
);
  localparam int D = 2**A;
`ifdef REG0_ZERO_EN
  localparam int LO = 1;
`else
  localparam int LO = 0;
`endif
  // entries below LO have no storage and read as zero
  logic [N-1:0] store [D-1:LO];
  assign wr_onehot = {{(D-1){1'b0}}, wr_ena} << wr_addr;
  always_ff @(posedge clk)
    for (int i = LO; i < D; i++)
      if (rst) store[i] <= '0;
      else if (wr_onehot[i]) store[i] <= wr_data;
  assign rd_data1 = int'(rd_addr1) < LO ? '0 : store[rd_addr1];
  assign rd_data2 = int'(rd_addr2) < LO ? '0 : store[rd_addr2];
endmodule

// File: tb/tb_decoder_register_bank.sv
// tb_decoder_register_bank: directed self-checking bench for decoder_register_bank
module tb_decoder_register_bank;
  logic        clk = 0;
  logic        rst;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic [31:0] wr_onehot;
  int n_chk = 0;
  int n_fail = 0;
  decoder_register_bank #(.N(32), .A(5)) dut (
    .clk(clk),
    .rst(rst),
    .wr_ena(wr_ena),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2),
    .rd_data1(rd_data1),
    .rd_data2(rd_data2),
    .wr_onehot(wr_onehot)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_ena = 1; wr_addr = a; wr_data = d;
    tick();
    wr_ena = 0;
  endtask
  initial begin
    logic [31:0] zero_exp;
    rst = 1; wr_ena = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF; rd_addr1 = 0; rd_addr2 = 0;
    // decoder sweep while rst holds, so no entry can be written
    for (int a = 0; a < 32; a++) begin
      wr_addr = 5'(a);
      #1 check("onehot_en", wr_onehot, 32'd1 << a);
    end
    wr_ena = 0;
    for (int a = 0; a < 32; a++) begin
      wr_addr = 5'(a);
      #1 check("onehot_dis", wr_onehot, 32'd0);
    end
    wr_ena = 1; wr_addr = 5; wr_data = 32'hFFFF_FFFF;
    tick();
    rst = 0; wr_ena = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a);
      #1 check("reset_rd1", rd_data1, 32'd0);
      check("reset_rd2", rd_data2, 32'd0);
    end
    write(7, 32'hDEAD_BEEF);
    wr_data = 32'h5555_5555; rd_addr1 = 7; rd_addr2 = 8;
    #1 check("wr_rd7", rd_data1, 32'hDEAD_BEEF);
    check("wr_rd8", rd_data2, 32'd0);
    tick();
    check("hold_rd7", rd_data1, 32'hDEAD_BEEF);
    write(0, 32'h1234_5678);
`ifdef REG0_ZERO_EN
    zero_exp = 32'd0;
`else
    zero_exp = 32'h1234_5678;
`endif
    rd_addr1 = 0; rd_addr2 = 0;
    #1 check("reg0_rd1", rd_data1, zero_exp);
    check("reg0_rd2", rd_data2, zero_exp);
    write(3, 32'hA);
    wr_ena = 1; wr_addr = 3; wr_data = 32'hB; rd_addr1 = 3; rd_addr2 = 3;
    #1 check("rdw_before", rd_data1, 32'hA);
    check("rdw_both", rd_data2, 32'hA);
    tick();
    wr_ena = 0;
    check("rdw_after1", rd_data1, 32'hB);
    check("rdw_after2", rd_data2, 32'hB);
    for (int k = 1; k < 32; k++) write(5'(k), 32'(k) * 32'h0101_0101);
    for (int k = 1; k < 32; k++) begin
      rd_addr1 = 5'(k); rd_addr2 = 5'((k % 31) + 1);
      #1 check("fill_rd1", rd_data1, 32'(k) * 32'h0101_0101);
      check("fill_rd2", rd_data2, 32'((k % 31) + 1) * 32'h0101_0101);
    end
    // reset beats a concurrent write
    rst = 1; wr_ena = 1; wr_addr = 9; wr_data = 32'hFFFF_0000;
    tick();
    rst = 0; wr_ena = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a);
      #1 check("midrst_rd1", rd_data1, 32'd0);
      check("midrst_rd2", rd_data2, 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
